// File: rtl/mem_pkg.sv
// Shared definitions for the memory request controller.
//   state_e : controller states (IDLE, RD_WAIT, RSP)
//   CNT_W   : width of the optional request statistics counters
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 16;

endpackage : mem_pkg

// File: rtl/mem_req_ctrl.sv
// Memory request controller: turns a valid/ready request stream into memory
// read/write strobes and returns read data over a valid/ready response port.
// At most one read is in flight; writes complete in their accept cycle.
//
// Parameters:
//   addr_w   - memory address width
//   data_w   - memory data width
//   buf_read - 0: memory read data valid in the accept cycle (combinational)
//              1: memory read data valid one cycle after the accept (registered)
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   req_valid/req_ready            - request handshake
//   req_write/req_addr/req_wdata   - request payload
//   rsp_valid/rsp_ready/rsp_rdata  - read response
//   mem_re/mem_raddr/mem_rdata     - memory read port (mem_re combinational)
//   mem_we/mem_waddr/mem_wdata     - memory write port (mem_we combinational)
//   rd_count/wr_count              - accept counters, only with MEM_REQ_STATS_EN
// Optional feature macro: MEM_REQ_STATS_EN
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned addr_w   = 5,
  parameter int unsigned data_w   = 32,
  parameter bit          buf_read = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [addr_w-1:0] req_addr,
  input  logic [data_w-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [data_w-1:0] rsp_rdata,
  output logic              mem_re,
  output logic [addr_w-1:0] mem_raddr,
  input  logic [data_w-1:0] mem_rdata,
  output logic              mem_we,
  output logic [addr_w-1:0] mem_waddr,
  output logic [data_w-1:0] mem_wdata
`ifdef MEM_REQ_STATS_EN
  ,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
`endif
);

  state_e            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [data_w-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              accept;
  logic              rd_accept;
  logic              wr_accept;

  // Ready is gated by rst so nothing is accepted (and no strobe fires) in reset.
  assign req_ready = !rst && ((state_q == IDLE) || ((state_q == RSP) && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_write;
  assign wr_accept = accept && req_write;

  assign mem_re    = rd_accept;
  assign mem_raddr = req_addr;
  assign mem_we    = wr_accept;
  assign mem_waddr = req_addr;
  assign mem_wdata = req_wdata;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // Next-state and response data capture.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      RD_WAIT: begin
        rsp_rdata_d = mem_rdata;
        state_d     = RSP;
      end
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A read accept can only occur in IDLE or in a retiring RSP; it overrides.
    if (rd_accept) begin
      if (buf_read) begin
        state_d = RD_WAIT;
      end else begin
        state_d     = RSP;
        rsp_rdata_d = mem_rdata;
      end
    end
    rsp_valid_d = (state_d == RSP);
  end

  // State and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef MEM_REQ_STATS_EN
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  // Saturating accept counters.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (rd_accept && (rd_count_q != {CNT_W{1'b1}})) rd_count_d = rd_count_q + CNT_W'(1);
    if (wr_accept && (wr_count_q != {CNT_W{1'b1}})) wr_count_d = wr_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule : mem_req_ctrl

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: instance 0 uses buf_read=0, instance 1 buf_read=1,
// each with its own memory model. Read expectations go into a per-instance
// queue on accept and are popped when the response handshakes.
module tb_mem_req_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready, req_write, rsp_valid, rsp_ready, mem_re, mem_we;
  logic [1:0][4:0]  req_addr, mem_raddr, mem_waddr;
  logic [1:0][31:0] req_wdata, rsp_rdata, mem_rdata, mem_wdata;
`ifdef MEM_REQ_STATS_EN
  logic [1:0][15:0] rd_count, wr_count;
`endif

  mem_req_ctrl #(.addr_w(5), .data_w(32), .buf_read(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .mem_re(mem_re[0]), .mem_raddr(mem_raddr[0]), .mem_rdata(mem_rdata[0]),
    .mem_we(mem_we[0]), .mem_waddr(mem_waddr[0]), .mem_wdata(mem_wdata[0])
`ifdef MEM_REQ_STATS_EN
    , .rd_count(rd_count[0]), .wr_count(wr_count[0])
`endif
  );

  mem_req_ctrl #(.addr_w(5), .data_w(32), .buf_read(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .mem_re(mem_re[1]), .mem_raddr(mem_raddr[1]), .mem_rdata(mem_rdata[1]),
    .mem_we(mem_we[1]), .mem_waddr(mem_waddr[1]), .mem_wdata(mem_wdata[1])
`ifdef MEM_REQ_STATS_EN
    , .rd_count(rd_count[1]), .wr_count(wr_count[1])
`endif
  );

  // Memory models: instance 0 combinational read, instance 1 registered read.
  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];
  logic [31:0] rdq1;
  always @(posedge clk) if (mem_we[0]) mem0[mem_waddr[0]] <= mem_wdata[0];
  always @(posedge clk) if (mem_we[1]) mem1[mem_waddr[1]] <= mem_wdata[1];
  always @(posedge clk) if (mem_re[1]) rdq1 <= mem1[mem_raddr[1]];
  assign mem_rdata[0] = mem0[mem_raddr[0]];
  assign mem_rdata[1] = rdq1;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: responses transfer at the posedge following this sample.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (sb0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
        else chk("rsp0_data", rsp_rdata[0], sb0.pop_front());
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (sb1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
        else chk("rsp1_data", rsp_rdata[1], sb1.pop_front());
      end
    end
  end

  // Drive one request from posedge+1; returns at posedge+1 after its accept.
  task automatic issue(input int d, input logic wr, input logic [4:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
    bit ok;
    ok = 1'b0;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      chk("mem_we_accept", 32'(mem_we[d]), 32'(wr));
      chk("mem_re_accept", 32'(mem_re[d]), 32'(!wr));
      if (wr) begin
        chk("mem_waddr", 32'(mem_waddr[d]), 32'(addr));
        chk("mem_wdata", mem_wdata[d], wdata);
      end else begin
        chk("mem_raddr", 32'(mem_raddr[d]), 32'(addr));
        if (d == 0) sb0.push_back(exp);
        else sb1.push_back(exp);
      end
    end
    step();
    req_valid[d] = 1'b0;
  endtask

  // Checks rsp_valid rises exactly lat cycles after the accept.
  task automatic lat_check(input int d, input int lat);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk($sformatf("latency%0d_cyc%0d", d, k), 32'(rsp_valid[d]), 32'(k == lat));
    end
    step();
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b1, 5'd1,  32'h11111111, 32'h0};
    vt[2] = '{1'b1, 5'd2,  32'h22222222, 32'h0};
    vt[3] = '{1'b0, 5'd1,  32'h0,        32'h11111111};
    vt[4] = '{1'b0, 5'd2,  32'h0,        32'h22222222};
    vt[5] = '{1'b0, 5'd3,  32'h0,        32'hDEADBEEF};
    vt[6] = '{1'b1, 5'd0,  32'h0BADF00D, 32'h0};
    vt[7] = '{1'b1, 5'd31, 32'hA5A5A5A5, 32'h0};
    vt[8] = '{1'b0, 5'd31, 32'h0,        32'hA5A5A5A5};
    vt[9] = '{1'b0, 5'd0,  32'h0,        32'h0BADF00D};

    // Reset state, with requests pending to show strobes stay low.
    rst       = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b10;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 2'b11;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("rst_mem_re", 32'(mem_re[d]), 32'd0);
      chk("rst_mem_we", 32'(mem_we[d]), 32'd0);
    end
    req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready0", 32'(req_ready[0]), 32'd1);
    chk("post_rst_ready1", 32'(req_ready[1]), 32'd1);
    step();

    // Write then read addr 3 with latency check on both instances.
    for (int d = 0; d < 2; d++) begin
      issue(d, 1'b1, 5'd3, 32'hDEADBEEF, 32'h0);
      @(negedge clk);
      chk("mem_we_pulse", 32'(mem_we[d]), 32'd0);
      step();
      issue(d, 1'b0, 5'd3, 32'h0, 32'hDEADBEEF);
      lat_check(d, (d == 1) ? 2 : 1);
    end

    // Table vectors, back-to-back requests with rsp_ready held high.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 10; i++)
        issue(d, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp);
    repeat (4) step();
    chk("table_sb0_empty", 32'(sb0.size()), 32'd0);
    chk("table_sb1_empty", 32'(sb1.size()), 32'd0);

    // Response stall on instance 1 with a competing read held.
    rsp_ready[1] = 1'b0;
    issue(1, 1'b0, 5'd3, 32'h0, 32'hDEADBEEF);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[1]  = 5'd1;
    @(negedge clk);
    chk("stall_rd_wait", 32'(rsp_valid[1]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid[1]), 32'd1);
      chk("stall_rsp_rdata", rsp_rdata[1], 32'hDEADBEEF);
      chk("stall_req_ready", 32'(req_ready[1]), 32'd0);
      chk("stall_mem_re", 32'(mem_re[1]), 32'd0);
    end
    step();
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    step();
    @(negedge clk);
    chk("stall_retired", 32'(rsp_valid[1]), 32'd0);
    chk("stall_sb1_empty", 32'(sb1.size()), 32'd0);
    step();

    // Write accepted while a response retires on instance 0.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 5'd2, 32'h0, 32'h22222222);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 5'd5;
    req_wdata[0] = 32'h55555555;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("wr_retire_ready", 32'(req_ready[0]), 32'd1);
    chk("wr_retire_mem_we", 32'(mem_we[0]), 32'd1);
    chk("wr_retire_waddr", 32'(mem_waddr[0]), 32'd5);
    step();
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    chk("wr_retire_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("wr_retire_idle", 32'(req_ready[0]), 32'd1);
    step();
    rsp_ready[0] = 1'b1;

    // Reset during RD_WAIT on instance 1 discards the read.
    issue(1, 1'b0, 5'd1, 32'h0, 32'h11111111);
    rst = 1'b1;
    #1;
    chk("rdwait_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("rdwait_rst_ready", 32'(req_ready[1]), 32'd0);
    sb1.delete();
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rdwait_post_ready", 32'(req_ready[1]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rdwait_no_rsp", 32'(rsp_valid[1]), 32'd0);
    end
    step();

`ifdef MEM_REQ_STATS_EN
    // Read counter saturation.
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("cnt_rst_rd", 32'(rd_count[0]), 32'd0);
    chk("cnt_rst_wr", 32'(wr_count[0]), 32'd0);
    step();
    for (int n = 0; n < 70000; n++) issue(0, 1'b0, 5'd3, 32'h0, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("cnt_rd_sat", 32'(rd_count[0]), 32'h0000FFFF);
    chk("cnt_wr_zero", 32'(wr_count[0]), 32'd0);
    chk("cnt_other_rd", 32'(rd_count[1]), 32'd0);
    step();
`endif

    repeat (3) step();
    chk("final_sb0_empty", 32'(sb0.size()), 32'd0);
    chk("final_sb1_empty", 32'(sb1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_req_ctrl

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have parameter addr_w, default 5, memory address width.
REQ-002 SHALL have parameter data_w, default 32, memory data width.
REQ-003 SHALL have parameter buf_read, default 1, memory read latency select: 0 = combinational read, 1 = registered read.
REQ-004 SHALL have port clk, input, 1, the only clock; all flops on posedge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports req_valid, input, 1 and req_ready, output, 1, the request handshake.
REQ-007 SHALL have ports req_write, input, 1; req_addr, input, addr_w; req_wdata, input, data_w, the request payload.
REQ-008 SHALL have ports rsp_valid, output, 1; rsp_ready, input, 1; rsp_rdata, output, data_w, the read response.
REQ-009 SHALL have ports mem_re, output, 1; mem_raddr, output, addr_w; mem_rdata, input, data_w, the memory read port.
REQ-010 SHALL have ports mem_we, output, 1; mem_waddr, output, addr_w; mem_wdata, output, data_w, the memory write port.

Function
REQ-011 SHALL accept a request in any cycle where req_valid && req_ready (the accept cycle).
REQ-012 SHALL, for an accepted write, drive mem_we=1 combinationally in the accept cycle with mem_waddr/mem_wdata = req_addr/req_wdata, and produce no response.
REQ-013 SHALL, for an accepted read, drive mem_re=1 combinationally in the accept cycle with mem_raddr=req_addr.
REQ-014 SHALL drive mem_re=0 and mem_we=0 in every cycle that is not an accept cycle.
REQ-015 SHALL implement states IDLE, RD_WAIT and RSP.
REQ-016 IDLE SHALL go to RD_WAIT on a read accept when buf_read=1, and to RSP when buf_read=0; it SHALL stay in IDLE on a write accept.
REQ-017 RD_WAIT SHALL last exactly one cycle, capture mem_rdata into rsp_rdata, and go to RSP.
REQ-018 With buf_read=0, a read SHALL capture mem_rdata into rsp_rdata at the end of its accept cycle.
REQ-019 SHALL assert rsp_valid only in RSP; rsp_rdata SHALL stay stable while rsp_valid && !rsp_ready.
REQ-020 Read latency from accept to rsp_valid SHALL be 1 cycle when buf_read=0 and 2 cycles when buf_read=1.
REQ-021 req_ready SHALL equal (state==IDLE) || (state==RSP && rsp_ready), and SHALL be 0 in RD_WAIT.
REQ-022 In RSP with rsp_ready=1, a simultaneous read accept SHALL retire the current response and start the new read (back-to-back, no bubble on the request side).
REQ-023 In RSP with rsp_ready=1, a simultaneous write accept SHALL retire the current response and go to IDLE.
REQ-024 In RSP with rsp_ready=1 and no accept, the block SHALL go to IDLE.
REQ-025 At most one read SHALL be outstanding at any time.

Reset
REQ-026 Asserting rst SHALL asynchronously force state=IDLE, rsp_valid=0, rsp_rdata=0 and req_ready=0.
REQ-027 While rst is high, mem_re and mem_we SHALL be 0.
REQ-028 A read in RD_WAIT or RSP when rst asserts SHALL be discarded, with no response after reset release.
REQ-029 req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro MEM_REQ_STATS_EN SHALL, when defined, add outputs rd_count[15:0] and wr_count[15:0].
REQ-031 rd_count and wr_count SHALL count read accepts and write accepts, saturate at 16'hFFFF, and reset to 0.
REQ-032 When MEM_REQ_STATS_EN is undefined, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 The state enum (IDLE, RD_WAIT, RSP) and the counter width constant SHALL live in shared package mem_pkg.
REQ-034 The block SHALL be a single module with no sub-module; the saturating counter is inline logic.

Verification
REQ-035 Reset, then write addr 3 = 32'hDEADBEEF, then read addr 3 -> mem_we pulses exactly one cycle; rsp_rdata=32'hDEADBEEF with rsp_valid asserted 2 cycles after the read accept (buf_read=1) and 1 cycle after (buf_read=0).
REQ-036 Read issued with rsp_ready=0 held for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, no mem_re pulse during the stall.
REQ-037 Reads to addrs 1, 2, 3 back-to-back with rsp_ready=1 and buf_read=0 -> one response per cycle, in order, no dropped or duplicated data.
REQ-038 rst asserted in RD_WAIT -> rsp_valid=0 immediately, no response after release, req_ready=1 on the first post-reset cycle.
REQ-039 Write accepted in the same cycle a response retires -> mem_we=1 that cycle, next state IDLE, rsp_valid=0.
REQ-040 MEM_REQ_STATS_EN defined, 70000 reads issued -> rd_count=16'hFFFF and wr_count=0.
